// File: rtl/cordic_square_pkg.sv
// Shared types for the square/reconstruct unit: FSM encoding and the done latency
// that schedulers and benches use to plan back-to-back issue.
package cordic_square_pkg;

   typedef enum logic [1:0] {SQ_IDLE, SQ_RUN, SQ_FIN} sq_state_t;

   function automatic int sq_latency(input int out_width);
      return out_width + 2;
   endfunction

endpackage

// File: rtl/cordic_square_if.sv
// Request/response bundle for cordic_square; the master issues root/rem pairs,
// the slave returns the rebuilt radicand with a one-cycle done pulse.
interface cordic_square_if #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = IN_WIDTH / 2
);
   logic                 start;
   logic [OUT_WIDTH-1:0] root_in;
   logic [OUT_WIDTH:0]   rem_in;
   logic                 neg_in;
   logic [IN_WIDTH-1:0]  x_out;
   logic                 done;
   logic                 busy;
   logic                 is_neg;
   logic                 err;

   modport master (output start, root_in, rem_in, neg_in,
                   input  x_out, done, busy, is_neg, err);
   modport slave  (input  start, root_in, rem_in, neg_in,
                   output x_out, done, busy, is_neg, err);
endinterface

// File: rtl/cordic_square.sv
// Rebuilds x = root*root + rem with a shift-add multiply, one multiplier bit per clock.
// Results and flags are registered on leaving FIN and hold until the next completion.
module cordic_square
   import cordic_square_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = IN_WIDTH / 2
) (
   input  logic              clk,
   input  logic              rst,
   cordic_square_if.slave    bus
);
   localparam int AW = IN_WIDTH + 1;
   localparam int CW = $clog2(OUT_WIDTH + 1);

   sq_state_t            state_q, state_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic [AW-1:0]        mcand_q, mcand_d;
   logic [OUT_WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]        iter_q, iter_d;
   logic                 err_rem_q, err_rem_d;
   logic                 neg_q, neg_d;
   logic [IN_WIDTH-1:0]  x_q, x_d;
   logic                 err_q, err_d;
   logic                 is_neg_q, is_neg_d;
   logic                 done_q, done_d;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      iter_d    = iter_q;
      err_rem_d = err_rem_q;
      neg_d     = neg_q;
      x_d       = x_q;
      err_d     = err_q;
      is_neg_d  = is_neg_q;
      done_d    = 1'b0;
      case (state_q)
         SQ_IDLE: begin
            if (bus.start) begin
               state_d = SQ_RUN;
               mcand_d = AW'(bus.root_in);
               iter_d  = CW'(OUT_WIDTH);
               neg_d   = bus.neg_in;
               // Negative inputs produce a forced zero, as the sqrt unit does.
               if (bus.neg_in) begin
                  mplier_d  = '0;
                  acc_d     = '0;
                  err_rem_d = 1'b0;
               end else begin
                  mplier_d  = bus.root_in;
                  acc_d     = AW'(bus.rem_in);
                  err_rem_d = bus.rem_in > {bus.root_in, 1'b0};
               end
            end
         end
         SQ_RUN: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            iter_d   = iter_q - 1'b1;
            if (iter_q == CW'(1)) state_d = SQ_FIN;
         end
         SQ_FIN: begin
            x_d      = acc_q[IN_WIDTH-1:0];
            err_d    = err_rem_q | acc_q[IN_WIDTH] | acc_q[IN_WIDTH-1];
            is_neg_d = neg_q;
            done_d   = 1'b1;
            state_d  = SQ_IDLE;
         end
         default: state_d = SQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SQ_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         iter_q    <= '0;
         err_rem_q <= 1'b0;
         neg_q     <= 1'b0;
         x_q       <= '0;
         err_q     <= 1'b0;
         is_neg_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         iter_q    <= iter_d;
         err_rem_q <= err_rem_d;
         neg_q     <= neg_d;
         x_q       <= x_d;
         err_q     <= err_d;
         is_neg_q  <= is_neg_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      bus.x_out  = x_q;
      bus.done   = done_q;
      bus.busy   = (state_q != SQ_IDLE);
      bus.is_neg = is_neg_q;
      bus.err    = err_q;
   end

endmodule

// File: tb/tb_cordic_square.sv
// Scoreboard bench for cordic_square: stimulus pushes expected results, a negedge
// monitor pops and compares value, flags and done timing.
module tb_cordic_square;
   import cordic_square_pkg::*;

   localparam int IW = 32;
   localparam int OW = 16;

   typedef struct {
      logic [IW-1:0] x;
      logic          err;
      logic          neg;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   cordic_square_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus();

   cordic_square #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: done=1 expected no done (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("x_out", longint'(bus.x_out), longint'(e.x));
            chk("err", longint'(bus.err), longint'(e.err));
            chk("is_neg", longint'(bus.is_neg), longint'(e.neg));
            chk("latency_cycle", longint'(cyc), longint'(e.cyc));
         end
      end
   end

   function automatic exp_t mk(input logic [IW-1:0] x, input logic err, input logic neg,
                               input int done_cyc);
      exp_t e;
      e.x = x; e.err = err; e.neg = neg; e.cyc = done_cyc;
      return e;
   endfunction

   // Issue one op at a negedge; start is sampled at the next posedge (edge cyc+1).
   task automatic issue(input logic [OW-1:0] root, input logic [OW:0] rem, input logic neg,
                        input logic [IW-1:0] ex, input logic eerr);
      @(negedge clk);
      bus.root_in = root;
      bus.rem_in  = rem;
      bus.neg_in  = neg;
      bus.start   = 1'b1;
      exp_q.push_back(mk(ex, eerr, neg, cyc + 1 + sq_latency(OW) - 1));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: %0d results outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int unsigned r, rm;
      longint      xl;
      int          base;
      bus.start = 1'b0; bus.root_in = '0; bus.rem_in = '0; bus.neg_in = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_x_out", longint'(bus.x_out), 0);
      chk("rst_done", longint'(bus.done), 0);
      chk("rst_busy", longint'(bus.busy), 0);
      chk("rst_err", longint'(bus.err), 0);
      chk("rst_is_neg", longint'(bus.is_neg), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed vectors
      issue(16'd12, 17'd5, 1'b0, 32'd149, 1'b0);               wait_done();
      issue(16'd46340, 17'd88047, 1'b0, 32'h7FFFFFFF, 1'b0);  wait_done();
      issue(16'd46340, 17'd88048, 1'b0, 32'h80000000, 1'b1);  wait_done();
      issue(16'hFFFF, 17'd0, 1'b0, 32'hFFFE0001, 1'b1);       wait_done();
      issue(16'd3, 17'd7, 1'b0, 32'd16, 1'b1);                wait_done();
      issue(16'd100, 17'd3, 1'b1, 32'd0, 1'b0);               wait_done();
      issue(16'd0, 17'd0, 1'b0, 32'd0, 1'b0);                 wait_done();
      issue(16'd0, 17'd1, 1'b0, 32'd1, 1'b1);                 wait_done();
      issue(16'd255, 17'd510, 1'b0, 32'd65535, 1'b0);         wait_done();

      // Starts while busy are ignored and inputs are not re-sampled
      issue(16'd12, 17'd5, 1'b0, 32'd149, 1'b0);
      @(negedge clk);
      bus.root_in = 16'd99; bus.rem_in = 17'd0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      bus.root_in = 16'd7; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();

      // Start held high: back-to-back ops every sq_latency cycles
      @(negedge clk);
      bus.root_in = 16'd7; bus.rem_in = 17'd3; bus.neg_in = 1'b0; bus.start = 1'b1;
      base = cyc + 1;
      for (int k = 0; k < 3; k++)
         exp_q.push_back(mk(32'd52, 1'b0, 1'b0, base + k * sq_latency(OW) + sq_latency(OW) - 1));
      while (cyc < base + 2 * sq_latency(OW) + 1) @(negedge clk);
      bus.start = 1'b0;
      wait_done();

      // Reset in the middle of a run discards the op and clears outputs at once
      issue(16'd200, 17'd0, 1'b0, 32'd40000, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_x_out", longint'(bus.x_out), 0);
      chk("midrst_busy", longint'(bus.busy), 0);
      chk("midrst_done", longint'(bus.done), 0);
      chk("midrst_err", longint'(bus.err), 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      chk("postrst_x_out", longint'(bus.x_out), 0);
      issue(16'd1000, 17'd1999, 1'b0, 32'd1001999, 1'b0);     wait_done();

      // Loopback-style sweep over legal root/remainder pairs
      for (int n = 0; n < 6; n++) begin
         r  = $urandom_range(0, 46340);
         rm = $urandom_range(0, 2 * r);
         xl = longint'(r) * longint'(r) + longint'(rm);
         issue(r[OW-1:0], rm[OW:0], 1'b0, xl[IW-1:0], xl > 64'h7FFFFFFF);
         wait_done();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
